// File: rtl/ctrl_regbank_pkg.sv
// Shared constants for the clk_b register bank: register map, interrupt bits,
// capture FSM encoding and the unmapped-read pattern.
package ctrl_regbank_pkg;

  localparam logic [3:0] REG_ID       = 4'h0;
  localparam logic [3:0] REG_CTRL     = 4'h1;
  localparam logic [3:0] REG_CAP_LEN  = 4'h2;
  localparam logic [3:0] REG_STATUS   = 4'h3;
  localparam logic [3:0] REG_INT_STAT = 4'h4;
  localparam logic [3:0] REG_INT_MASK = 4'h5;
  localparam logic [3:0] REG_SCRATCH  = 4'h6;
  localparam logic [3:0] REG_CAP_CNT  = 4'h7;

  localparam int INT_DONE = 0;
  localparam int INT_OVF  = 1;
  localparam int INT_ERR  = 2;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  function automatic logic is_mapped(input logic [3:0] idx);
    return (idx <= REG_CAP_CNT);
  endfunction

endpackage

// File: rtl/ctrl_regbank_if.sv
// Single-cycle register access presented by the clock-domain crossing;
// read data returns combinationally in the same cycle.
interface ctrl_regbank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19
);
  logic                  valid_b;
  logic                  write_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic [DATA_WIDTH-1:0] rdata_b;

  modport master (output valid_b, output write_b, output addr_b, output wdata_b, input rdata_b);
  modport slave  (input valid_b, input write_b, input addr_b, input wdata_b, output rdata_b);
endinterface

// File: rtl/ctrl_regbank_cap_fsm.sv
// Capture sequencer IDLE -> CAPTURE -> DONE; latches the length at START so
// later CAP_LEN writes do not disturb a running capture.
module ctrl_cap_fsm
  import ctrl_regbank_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [15:0] i_len,
  input  logic       i_sample,
  output cap_state_e o_state,
  output logic [15:0] o_cnt,
  output logic       o_cap_start,
  output logic       o_cap_active,
  output logic       o_done
);

  cap_state_e  r_state;
  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic        r_cap_start;
  logic        r_cap_active;
  logic        r_done;

  // State, latched length, sample count and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_len        <= 16'd0;
      r_cnt        <= 16'd0;
      r_cap_start  <= 1'b0;
      r_cap_active <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_cap_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            r_cnt <= 16'd0;
            r_len <= i_len;
            if (i_len == 16'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_CAPTURE;
              r_cap_start  <= 1'b1;
              r_cap_active <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (i_abort) begin
            r_state      <= ST_IDLE;
            r_cap_active <= 1'b0;
          end else if (i_sample) begin
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt == r_len - 16'd1) begin
              r_state      <= ST_DONE;
              r_cap_active <= 1'b0;
              r_done       <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cap_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_cnt        = r_cnt;
  assign o_cap_start  = r_cap_start;
  assign o_cap_active = r_cap_active;
  assign o_done       = r_done;

endmodule

// File: rtl/ctrl_regbank.sv
// clk_b register bank: decode, registers, interrupt aggregation and the capture FSM.
// Optional CTRL_REGBANK_ERR_EN flags unmapped accesses in INT_STAT.ERR.
module ctrl_regbank
  import ctrl_regbank_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 19,
  parameter logic [31:0] ID_VALUE   = 32'h4144_4331
) (
  input  logic                 clk_b,
  input  logic                 rst_b,
  ctrl_regbank_if.slave        bus,
  input  logic                 sample_vld_b,
  input  logic                 ovf_b,
  output logic                 cap_start_b,
  output logic                 cap_active_b,
  output logic [15:0]          cap_len_b,
  output logic                 irq_b
);

`ifdef CTRL_REGBANK_ERR_EN
  localparam logic [DATA_WIDTH-1:0] W_UNMAPPED = DATA_WIDTH'(ERR_PATTERN);
`else
  localparam logic [DATA_WIDTH-1:0] W_UNMAPPED = {DATA_WIDTH{1'b0}};
`endif

  logic [3:0]            w_idx;
  logic                  w_hit;
  logic                  w_wr;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_err_set;
  logic [2:0]            w_set;
  logic [2:0]            w_clr;
  logic [DATA_WIDTH-1:0] w_rdata;
  cap_state_e            w_state;
  logic [15:0]           w_cnt;
  logic                  w_done;

  logic [15:0]           r_cap_len;
  logic [2:0]            r_int_stat;
  logic [2:0]            r_int_mask;
  logic [DATA_WIDTH-1:0] r_scratch;
  logic                  r_irq;

  assign w_idx   = bus.addr_b[3:0];
  assign w_hit   = (~|bus.addr_b[ADDR_WIDTH-1:4]) & is_mapped(w_idx);
  assign w_wr    = bus.valid_b & bus.write_b & w_hit;
  assign w_start = w_wr & (w_idx == REG_CTRL) & bus.wdata_b[0];
  assign w_abort = w_wr & (w_idx == REG_CTRL) & bus.wdata_b[1];

`ifdef CTRL_REGBANK_ERR_EN
  assign w_err_set = bus.valid_b & ~w_hit;
`else
  assign w_err_set = 1'b0;
`endif

  // Hardware set takes priority over a same-cycle write-1-to-clear
  assign w_set = {w_err_set, ovf_b, w_done};
  assign w_clr = (w_wr && (w_idx == REG_INT_STAT)) ? bus.wdata_b[2:0] : 3'b000;

  ctrl_cap_fsm u_fsm (
    .clk          (clk_b),
    .rst          (rst_b),
    .i_start      (w_start),
    .i_abort      (w_abort),
    .i_len        (r_cap_len),
    .i_sample     (sample_vld_b),
    .o_state      (w_state),
    .o_cnt        (w_cnt),
    .o_cap_start  (cap_start_b),
    .o_cap_active (cap_active_b),
    .o_done       (w_done)
  );

  // Software-writable configuration registers
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      r_cap_len  <= 16'd0;
      r_int_mask <= 3'b000;
      r_scratch  <= {DATA_WIDTH{1'b0}};
    end else if (w_wr) begin
      case (w_idx)
        REG_CAP_LEN:  r_cap_len  <= bus.wdata_b[15:0];
        REG_INT_MASK: r_int_mask <= bus.wdata_b[2:0];
        REG_SCRATCH:  r_scratch  <= bus.wdata_b;
        default:      ;
      endcase
    end
  end

  // Sticky interrupt status and the registered interrupt line
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      r_int_stat <= 3'b000;
      r_irq      <= 1'b0;
    end else begin
      r_int_stat <= (r_int_stat & ~w_clr) | w_set;
      r_irq      <= |(r_int_stat & r_int_mask);
    end
  end

  // Zero-latency read mux, quiet unless a read is in progress
  always_comb begin
    w_rdata = {DATA_WIDTH{1'b0}};
    if (rst_b || !bus.valid_b || bus.write_b) begin
      w_rdata = {DATA_WIDTH{1'b0}};
    end else if (!w_hit) begin
      w_rdata = W_UNMAPPED;
    end else begin
      case (w_idx)
        REG_ID:       w_rdata = DATA_WIDTH'(ID_VALUE);
        REG_CTRL:     w_rdata = {DATA_WIDTH{1'b0}};
        REG_CAP_LEN:  w_rdata = DATA_WIDTH'(r_cap_len);
        REG_STATUS:   w_rdata = DATA_WIDTH'({w_state != ST_IDLE, w_state});
        REG_INT_STAT: w_rdata = DATA_WIDTH'(r_int_stat);
        REG_INT_MASK: w_rdata = DATA_WIDTH'(r_int_mask);
        REG_SCRATCH:  w_rdata = r_scratch;
        REG_CAP_CNT:  w_rdata = DATA_WIDTH'(w_cnt);
        default:      w_rdata = {DATA_WIDTH{1'b0}};
      endcase
    end
  end

  assign bus.rdata_b = w_rdata;
  assign cap_len_b   = r_cap_len;
  assign irq_b       = r_irq;

endmodule

// File: tb/tb_ctrl_regbank.sv
// Directed bench for ctrl_regbank with hand-computed expectations;
// honours CTRL_REGBANK_ERR_EN for the unmapped-access checks.
module tb_ctrl_regbank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_vld = 1'b0;
  logic ovf = 1'b0;
  logic cap_start;
  logic cap_active;
  logic [15:0] cap_len;
  logic irq;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

`ifdef CTRL_REGBANK_ERR_EN
  localparam logic [31:0] EXP_UNMAPPED = 32'hDEAD_BEEF;
  localparam logic [31:0] EXP_ERR_STAT = 32'h0000_0004;
`else
  localparam logic [31:0] EXP_UNMAPPED = 32'h0000_0000;
  localparam logic [31:0] EXP_ERR_STAT = 32'h0000_0000;
`endif

  ctrl_regbank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(19)) bus_if ();

  ctrl_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(19), .ID_VALUE(32'h4144_4331)) dut (
    .clk_b        (clk),
    .rst_b        (rst),
    .bus          (bus_if),
    .sample_vld_b (sample_vld),
    .ovf_b        (ovf),
    .cap_start_b  (cap_start),
    .cap_active_b (cap_active),
    .cap_len_b    (cap_len),
    .irq_b        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [18:0] addr, input logic [31:0] data);
    bus_if.valid_b = 1'b1;
    bus_if.write_b = 1'b1;
    bus_if.addr_b  = addr;
    bus_if.wdata_b = data;
    tick();
    bus_if.valid_b = 1'b0;
    bus_if.write_b = 1'b0;
  endtask

  task automatic do_read(input logic [18:0] addr, output logic [31:0] data);
    bus_if.valid_b = 1'b1;
    bus_if.write_b = 1'b0;
    bus_if.addr_b  = addr;
    #2;
    data = bus_if.rdata_b;
    tick();
    bus_if.valid_b = 1'b0;
  endtask

  task automatic pulse_sample();
    sample_vld = 1'b1;
    tick();
    sample_vld = 1'b0;
  endtask

  initial begin
    bus_if.valid_b = 1'b0;
    bus_if.write_b = 1'b0;
    bus_if.addr_b  = 19'd0;
    bus_if.wdata_b = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_cap_start", {31'd0, cap_start}, 32'd0);
    check("rst_cap_active", {31'd0, cap_active}, 32'd0);
    check("rst_cap_len", {16'd0, cap_len}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", bus_if.rdata_b, 32'd0);

    do_read(19'h0, rd); check("id", rd, 32'h4144_4331);
    do_read(19'h6, rd); check("scratch_rst", rd, 32'd0);
    do_write(19'h6, 32'hA5A5_1234);
    do_read(19'h6, rd); check("scratch_rb", rd, 32'hA5A5_1234);
    do_read(19'h1, rd); check("ctrl_rd0", rd, 32'd0);

    // Four-sample capture; CAP_LEN rewritten mid-capture must not matter
    do_write(19'h2, 32'd4);
    check("cap_len_out", {16'd0, cap_len}, 32'd4);
    do_write(19'h1, 32'd1);
    check("cap_start_pulse", {31'd0, cap_start}, 32'd1);
    check("cap_active_on", {31'd0, cap_active}, 32'd1);
    tick();
    check("cap_start_end", {31'd0, cap_start}, 32'd0);
    do_read(19'h3, rd); check("status_capture", rd, 32'd5);
    pulse_sample();
    pulse_sample();
    do_write(19'h2, 32'd9);
    pulse_sample();
    check("active_mid", {31'd0, cap_active}, 32'd1);
    pulse_sample();
    check("active_off", {31'd0, cap_active}, 32'd0);
    do_read(19'h3, rd); check("status_done", rd, 32'd6);
    do_read(19'h7, rd); check("cap_cnt", rd, 32'd4);
    do_read(19'h4, rd); check("int_done", rd, 32'd1);
    do_read(19'h2, rd); check("cap_len_rb", rd, 32'd9);
    check("irq_masked", {31'd0, irq}, 32'd0);

    do_write(19'h5, 32'd1);
    check("irq_lat", {31'd0, irq}, 32'd0);
    tick();
    check("irq_on", {31'd0, irq}, 32'd1);
    do_write(19'h4, 32'd1);
    check("irq_clr_lat", {31'd0, irq}, 32'd1);
    tick();
    check("irq_off", {31'd0, irq}, 32'd0);

    // Zero length goes straight to DONE without a start pulse
    do_write(19'h2, 32'd0);
    do_write(19'h1, 32'd1);
    check("len0_no_start", {31'd0, cap_start}, 32'd0);
    check("len0_no_active", {31'd0, cap_active}, 32'd0);
    do_read(19'h3, rd); check("len0_status", rd, 32'd6);
    do_read(19'h4, rd); check("len0_int", rd, 32'd1);
    do_write(19'h4, 32'd7);

    // START and ABORT together, then START ignored while busy, then ABORT
    do_write(19'h2, 32'd4);
    do_write(19'h1, 32'd3);
    check("sa_no_active", {31'd0, cap_active}, 32'd0);
    check("sa_no_start", {31'd0, cap_start}, 32'd0);
    do_read(19'h3, rd); check("sa_status", rd, 32'd0);
    do_write(19'h1, 32'd1);
    pulse_sample();
    do_write(19'h1, 32'd1);
    do_read(19'h7, rd); check("restart_ignored", rd, 32'd1);
    do_write(19'h1, 32'd2);
    check("abort_active", {31'd0, cap_active}, 32'd0);
    do_read(19'h3, rd); check("abort_status", rd, 32'd0);
    do_read(19'h4, rd); check("abort_no_done", rd, 32'd0);

    // Overflow set beats a same-cycle clear
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    do_read(19'h4, rd); check("ovf_set", rd, 32'd2);
    ovf = 1'b1;
    do_write(19'h4, 32'd2);
    ovf = 1'b0;
    do_read(19'h4, rd); check("ovf_set_wins", rd, 32'd2);
    do_write(19'h4, 32'd2);
    do_read(19'h4, rd); check("ovf_cleared", rd, 32'd0);

    // Unmapped index and nonzero upper address bits
    do_read(19'h9, rd); check("unmapped_rd", rd, EXP_UNMAPPED);
    do_read(19'h4, rd); check("err_stat", rd, EXP_ERR_STAT);
    do_write(19'h4, 32'd4);
    do_read(19'h10, rd); check("upper_rd", rd, EXP_UNMAPPED);
    do_write(19'h16, 32'h1111_2222);
    do_read(19'h6, rd); check("upper_wr_ignored", rd, 32'hA5A5_1234);

    // Asynchronous reset in the middle of a capture
    do_write(19'h2, 32'd4);
    do_write(19'h1, 32'd1);
    check("pre_rst_active", {31'd0, cap_active}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_active", {31'd0, cap_active}, 32'd0);
    check("async_rst_len", {16'd0, cap_len}, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_read(19'h6, rd); check("post_rst_scratch", rd, 32'd0);
    do_read(19'h3, rd); check("post_rst_status", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
